// File: rtl/nb_sum_chain.sv
// nb_sum_chain: streams x=a+b and y=a+b+x_prev through an elastic
// pipeline, with optional saturation and an output-change counter.
module nb_sum_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int SAT    = 0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             ovf,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [WIDTH+1:0] MAX = {2'b00, {WIDTH{1'b1}}};

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             ovf;
   } smp_t;

   smp_t              d [STAGES];
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0]  x_prev;
   logic [WIDTH-1:0]  hist;
   logic [WIDTH+1:0]  s;
   logic [WIDTH+1:0]  t;
   smp_t              nxt;
   logic              acc;
   logic              xfer;
   logic [WIDTH-1:0]  lx;
   logic [WIDTH-1:0]  ly;
   logic [CNT_W-1:0]  cnt;

   // Load enables ripple back from the consumer: a stage may load
   // when it is empty or its content moves on this cycle.
   always_comb begin
      logic r;
      r  = out_ready;
      ld = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r     = !v[k] || r;
         ld[k] = r;
      end
   end

   assign in_ready  = ld[0];
   assign acc       = in_valid && ld[0];
   assign out_valid = v[STAGES-1];
   assign xfer      = out_valid && out_ready;
   assign x         = d[STAGES-1].x;
   assign y         = d[STAGES-1].y;
   assign ovf       = d[STAGES-1].ovf;
   assign chg_cnt   = cnt;

   // Sums in WIDTH+2 bits; a clear in the accept cycle zeroes history.
   always_comb begin
      hist    = clr ? '0 : x_prev;
      s       = {2'b00, a} + {2'b00, b};
      t       = s + {2'b00, hist};
      nxt.x   = (SAT != 0 && s > MAX) ? MAX[WIDTH-1:0] : s[WIDTH-1:0];
      nxt.y   = (SAT != 0 && t > MAX) ? MAX[WIDTH-1:0] : t[WIDTH-1:0];
      nxt.ovf = (s > MAX) || (t > MAX);
   end

   // Stage registers; data only moves alongside a valid token.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int k = 0; k < STAGES; k++) d[k] <= '0;
      end else begin
         if (ld[0]) begin
            v[0] <= acc;
            if (acc) d[0] <= nxt;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) d[k] <= d[k-1];
            end
         end
      end
   end

   // History follows input order, independent of back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      x_prev <= '0;
      else if (acc) x_prev <= nxt.x;
      else if (clr) x_prev <= '0;
   end

   // Counts transfers whose pair differs from the last transferred pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         lx  <= '0;
         ly  <= '0;
      end else if (clr) begin
         cnt <= '0;
         lx  <= '0;
         ly  <= '0;
      end else if (xfer) begin
         lx <= x;
         ly <= y;
         if ((x != lx || y != ly) && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
      end
   end

endmodule
